// File: rtl/vta_queue_pkg.sv
// rtl/vta_queue_pkg.sv - shared widths, parameter check and op encoding for the VTA queues
package vta_queue_pkg;

    // Per-cycle queue operation after bypass and flush have been resolved.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_DEQ  = 2'b01,
        OP_ENQ  = 2'b10,
        OP_BOTH = 2'b11
    } q_op_e;

    // Pointer width; a floor of 1 keeps the vector legal even if an illegal DEPTH
    // slips through to the point where the parameter check reports it.
    function automatic int ptr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Occupancy width: must hold the value DEPTH itself, not just DEPTH-1.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit params_ok(input int width, input int depth, input int afull_th);
        return (width >= 1) && (depth >= 2) && (afull_th <= depth);
    endfunction

endpackage

// File: rtl/sync_queue_mem.sv
// rtl/sync_queue_mem.sv - WIDTH x DEPTH storage, one clocked write port, one asynchronous read port
// Ports:
//   clock      write clock
//   i_wr_en    write strobe for this edge
//   i_wr_addr  write row
//   i_wr_data  write data
//   i_rd_addr  read row (combinational read)
//   o_rd_data  contents of i_rd_addr
// Storage is isolated here so it can later be replaced by an SRAM macro wrapper.
module sync_queue_mem #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clock,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    // Contents are intentionally not reset.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sync_queue_param.sv
// rtl/sync_queue_param.sv - parametrised first-word-fall-through FIFO with ready/valid, flush and flags
// Ports:
//   clock, reset        single clock; synchronous active-high reset
//   io_enq_*            enqueue handshake (ready = not full, independent of deq side)
//   io_deq_*            dequeue handshake; bits show the head entry, or the enq bits
//                       when FLOW=1 and the queue is empty
//   io_flush            synchronous discard of all contents; fires in that cycle are dropped
//   io_count            current occupancy 0..DEPTH
//   io_almost_full      io_count >= AFULL_TH
//   io_almost_empty     io_count <= AEMPTY_TH
module sync_queue_param
    import vta_queue_pkg::*;
#(
    parameter int WIDTH     = 128,
    parameter int DEPTH     = 8,
    parameter int FLOW      = 0,
    parameter int AFULL_TH  = DEPTH - 1,
    parameter int AEMPTY_TH = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic                       io_enq_ready,
    input  logic                       io_enq_valid,
    input  logic [WIDTH-1:0]           io_enq_bits,
    input  logic                       io_deq_ready,
    output logic                       io_deq_valid,
    output logic [WIDTH-1:0]           io_deq_bits,
    input  logic                       io_flush,
    output logic [cnt_w(DEPTH)-1:0]    io_count,
    output logic                       io_almost_full,
    output logic                       io_almost_empty
);

    localparam int PW      = ptr_w(DEPTH);
    localparam int CW      = cnt_w(DEPTH);
    localparam bit FLOW_EN = (FLOW != 0);

    generate
        if (!params_ok(WIDTH, DEPTH, AFULL_TH)) begin : g_bad_params
            $error("sync_queue_param: illegal parameters (need WIDTH>=1, DEPTH>=2, AFULL_TH<=DEPTH)");
        end
    endgenerate

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_enq_fire;
    logic             w_deq_fire;
    logic             w_pass;
    logic             w_wr_en;
    logic [WIDTH-1:0] w_rd_data;
    q_op_e            w_op;

    // Pointers wrap at DEPTH-1 explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    assign io_enq_ready = !w_full;
    // When empty with FLOW=1 the producer is presented straight to the consumer.
    assign io_deq_valid = w_empty ? (FLOW_EN && io_enq_valid) : 1'b1;
    assign io_deq_bits  = (FLOW_EN && w_empty) ? io_enq_bits : w_rd_data;

    assign w_enq_fire = io_enq_valid && io_enq_ready;
    assign w_deq_fire = io_deq_valid && io_deq_ready;

    // A same-cycle bypass consumes the entry without touching memory, pointers or count.
    assign w_pass = FLOW_EN && w_empty && w_enq_fire && w_deq_fire;

    assign w_op    = q_op_e'({w_enq_fire && !w_pass, w_deq_fire && !w_pass});
    assign w_wr_en = ((w_op == OP_ENQ) || (w_op == OP_BOTH)) && !io_flush && !reset;

    always_ff @(posedge clock) begin
        if (reset || io_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            case (w_op)
                OP_ENQ: begin
                    r_wr_ptr <= ptr_inc(r_wr_ptr);
                    r_count  <= r_count + CW'(1);
                end
                OP_DEQ: begin
                    r_rd_ptr <= ptr_inc(r_rd_ptr);
                    r_count  <= r_count - CW'(1);
                end
                OP_BOTH: begin
                    r_wr_ptr <= ptr_inc(r_wr_ptr);
                    r_rd_ptr <= ptr_inc(r_rd_ptr);
                end
                default: begin
                end
            endcase
        end
    end

    assign io_count        = r_count;
    // Flags look only at the registered count, never at this cycle's handshakes.
    assign io_almost_full  = (int'(r_count) >= AFULL_TH);
    assign io_almost_empty = (int'(r_count) <= AEMPTY_TH);

    sync_queue_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_mem (
        .clock     (clock),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (io_enq_bits),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

endmodule

// File: tb/tb_sync_queue_param.sv
// tb/tb_sync_queue_param.sv - randomized and directed bench for sync_queue_param against a queue model
module tb_sync_queue_param;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;

    // Instance A: WIDTH=128, DEPTH=4, FLOW=0, default thresholds (AFULL_TH=3, AEMPTY_TH=1)
    logic         a_enq_ready, a_enq_valid, a_deq_ready, a_deq_valid, a_flush;
    logic         a_afull, a_aempty;
    logic [127:0] a_enq_bits, a_deq_bits;
    logic [2:0]   a_count;

    // Instance B: WIDTH=8, DEPTH=5, FLOW=1, AFULL_TH=4, AEMPTY_TH=2
    logic         b_enq_ready, b_enq_valid, b_deq_ready, b_deq_valid, b_flush;
    logic         b_afull, b_aempty;
    logic [7:0]   b_enq_bits, b_deq_bits;
    logic [2:0]   b_count;

    sync_queue_param #(.WIDTH(128), .DEPTH(4), .FLOW(0)) u_dut_a (
        .clock           (clock),
        .reset           (reset),
        .io_enq_ready    (a_enq_ready),
        .io_enq_valid    (a_enq_valid),
        .io_enq_bits     (a_enq_bits),
        .io_deq_ready    (a_deq_ready),
        .io_deq_valid    (a_deq_valid),
        .io_deq_bits     (a_deq_bits),
        .io_flush        (a_flush),
        .io_count        (a_count),
        .io_almost_full  (a_afull),
        .io_almost_empty (a_aempty)
    );

    sync_queue_param #(.WIDTH(8), .DEPTH(5), .FLOW(1), .AFULL_TH(4), .AEMPTY_TH(2)) u_dut_b (
        .clock           (clock),
        .reset           (reset),
        .io_enq_ready    (b_enq_ready),
        .io_enq_valid    (b_enq_valid),
        .io_enq_bits     (b_enq_bits),
        .io_deq_ready    (b_deq_ready),
        .io_deq_valid    (b_deq_valid),
        .io_deq_bits     (b_deq_bits),
        .io_flush        (b_flush),
        .io_count        (b_count),
        .io_almost_full  (b_afull),
        .io_almost_empty (b_aempty)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: each queue's contents in order, plus everything dequeued so far.
    logic [127:0] qa[$];
    logic [7:0]   qb[$];
    logic [127:0] outa[$];
    logic [7:0]   outb[$];
    bit           model_valid = 1'b0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Check both DUTs against the model at the falling edge, then advance the model
    // with the handshakes that the rising edge commits.
    task automatic tick();
        bit           a_enq, a_deq, b_enq, b_deq, b_vld;
        logic [7:0]   b_bits;
        @(negedge clock);
        b_vld  = (qb.size() > 0) || b_enq_valid;
        b_bits = (qb.size() > 0) ? qb[0] : b_enq_bits;
        if (model_valid) begin
            chk("a_enq_ready", 128'(a_enq_ready), 128'(qa.size() < 4));
            chk("a_deq_valid", 128'(a_deq_valid), 128'(qa.size() > 0));
            chk("a_count",     128'(a_count),     128'(qa.size()));
            chk("a_afull",     128'(a_afull),     128'(qa.size() >= 3));
            chk("a_aempty",    128'(a_aempty),    128'(qa.size() <= 1));
            if (qa.size() > 0) chk("a_deq_bits", a_deq_bits, qa[0]);
            chk("b_enq_ready", 128'(b_enq_ready), 128'(qb.size() < 5));
            chk("b_deq_valid", 128'(b_deq_valid), 128'(b_vld));
            chk("b_count",     128'(b_count),     128'(qb.size()));
            chk("b_afull",     128'(b_afull),     128'(qb.size() >= 4));
            chk("b_aempty",    128'(b_aempty),    128'(qb.size() <= 2));
            if (b_vld) chk("b_deq_bits", 128'(b_deq_bits), 128'(b_bits));
        end
        a_enq = a_enq_valid && (qa.size() < 4);
        a_deq = a_deq_ready && (qa.size() > 0);
        b_enq = b_enq_valid && (qb.size() < 5);
        b_deq = b_deq_ready && b_vld;
        @(posedge clock);
        if (reset) begin
            qa.delete();
            qb.delete();
            model_valid = 1'b1;
        end else begin
            if (a_flush) begin
                qa.delete();
            end else begin
                if (a_deq) outa.push_back(qa.pop_front());
                if (a_enq) qa.push_back(a_enq_bits);
            end
            if (b_flush) begin
                qb.delete();
            end else if (qb.size() == 0 && b_enq && b_deq) begin
                outb.push_back(b_enq_bits);
            end else begin
                if (b_deq) outb.push_back(qb.pop_front());
                if (b_enq) qb.push_back(b_enq_bits);
            end
        end
        #1;
    endtask

    initial begin
        int  nextb;
        int  cyc;
        bit  acc;

        reset       = 1'b1;
        a_enq_valid = 1'b0; a_enq_bits = '0; a_deq_ready = 1'b0; a_flush = 1'b0;
        b_enq_valid = 1'b0; b_enq_bits = '0; b_deq_ready = 1'b0; b_flush = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Reset state
        chk("rst_enq_ready", 128'(a_enq_ready), 128'(1));
        chk("rst_deq_valid", 128'(a_deq_valid), 128'(0));
        chk("rst_count",     128'(a_count),     128'(0));
        chk("rst_aempty",    128'(a_aempty),    128'(1));

        // Flow-through on B: empty queue, enq and deq in the same cycle
        b_enq_valid = 1'b1; b_enq_bits = 8'hAB; b_deq_ready = 1'b1;
        tick();
        b_enq_valid = 1'b0; b_deq_ready = 1'b0;
        chk("flow_count", 128'(b_count), 128'(0));
        chk("flow_out",   128'(outb.size() == 1 && outb[0] == 8'hAB), 128'(1));

        // Fill A back-to-back with no consumer
        a_deq_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            a_enq_valid = 1'b1;
            a_enq_bits  = 128'(i);
            tick();
            chk("fill_count", 128'(a_count), 128'(i));
        end
        chk("full_enq_ready", 128'(a_enq_ready), 128'(0));
        chk("full_afull",     128'(a_afull),     128'(1));
        a_enq_bits = 128'h5;
        tick();
        tick();
        chk("no_fifth", 128'(a_count), 128'(4));

        // Drain while 0x5 is offered; it may only enter once space opens
        a_deq_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            acc = a_enq_valid && (qa.size() < 4);
            tick();
            if (acc) a_enq_valid = 1'b0;
        end
        chk("drain_len", 128'(outa.size()), 128'(5));
        for (int i = 0; i < outa.size() && i < 5; i++) begin
            chk("drain_order", outa[i], 128'(i + 1));
        end

        // Flush at count 3 together with an enqueue of 0x7
        outa.delete();
        a_deq_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_enq_valid = 1'b1;
            a_enq_bits  = 128'(8'h11 + i);
            tick();
        end
        chk("pre_flush_count", 128'(a_count), 128'(3));
        a_flush = 1'b1; a_enq_valid = 1'b1; a_enq_bits = 128'h7;
        tick();
        a_flush = 1'b0; a_enq_valid = 1'b0;
        chk("flush_count",     128'(a_count),     128'(0));
        chk("flush_deq_valid", 128'(a_deq_valid), 128'(0));
        a_enq_valid = 1'b1; a_enq_bits = 128'h9; a_deq_ready = 1'b1;
        tick();
        a_enq_valid = 1'b0;
        tick();
        tick();
        chk("post_flush_len", 128'(outa.size()), 128'(1));
        if (outa.size() > 0) chk("post_flush_head", outa[0], 128'h9);

        // Reset in the middle of operation
        a_deq_ready = 1'b0;
        a_enq_valid = 1'b1; a_enq_bits = 128'h21;
        tick();
        a_enq_bits = 128'h22;
        tick();
        a_enq_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_count",     128'(a_count),     128'(0));
        chk("midrst_deq_valid", 128'(a_deq_valid), 128'(0));
        chk("midrst_aempty",    128'(a_aempty),    128'(1));

        // Random traffic: A with occasional flush, B streaming 0..19 through DEPTH=5
        outb.delete();
        nextb = 0;
        cyc   = 0;
        while ((outb.size() < 20 || cyc < 300) && cyc < 4000) begin
            a_enq_valid = 1'($urandom_range(0, 1));
            a_enq_bits  = {$urandom(), $urandom(), $urandom(), $urandom()};
            a_deq_ready = 1'($urandom_range(0, 1));
            a_flush     = ($urandom_range(0, 31) == 0);
            b_enq_valid = (nextb < 20) && ($urandom_range(0, 2) != 0);
            b_enq_bits  = 8'(nextb);
            b_deq_ready = ($urandom_range(0, 2) == 0);
            acc = b_enq_valid && (qb.size() < 5);
            tick();
            if (acc) nextb++;
            cyc++;
        end
        a_flush = 1'b0; a_enq_valid = 1'b0; b_enq_valid = 1'b0;
        chk("b_stream_len", 128'(outb.size()), 128'(20));
        for (int i = 0; i < outb.size() && i < 20; i++) begin
            chk("b_stream_order", 128'(outb[i]), 128'(i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sync_queue_param.md
Name: sync_queue_param

Overview:
- Parametrised synchronous FIFO with ready/valid handshakes on enqueue and dequeue.
- Generalises the fixed 128-bit single-mode queue. Width and depth are configurable.
- Adds occupancy count, almost-full/almost-empty flags, synchronous flush and optional same-cycle flow-through.
- Used between VTA load/store/compute stages wherever a decoupled buffer of configurable depth is needed.

Parameters:
- WIDTH, 128, data bits per entry (>=1).
- DEPTH, 8, number of entries (>=2, any integer, not restricted to power of two).
- FLOW, 0, 1 enables combinational enq->deq bypass when empty.
- AFULL_TH, DEPTH-1, io_almost_full asserted when count >= AFULL_TH.
- AEMPTY_TH, 1, io_almost_empty asserted when count <= AEMPTY_TH.

Ports:
- clock  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- io_enq_ready  out  1  queue can accept an entry this cycle.
- io_enq_valid  in  1  producer offers io_enq_bits.
- io_enq_bits  in  WIDTH  enqueue data.
- io_deq_ready  in  1  consumer accepts this cycle.
- io_deq_valid  out  1  io_deq_bits valid.
- io_deq_bits  out  WIDTH  head entry (or bypassed enq data).
- io_flush  in  1  synchronous discard of all contents.
- io_count  out  $clog2(DEPTH+1)  current occupancy.
- io_almost_full  out  1  count >= AFULL_TH.
- io_almost_empty  out  1  count <= AEMPTY_TH.

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset). Reset is sampled only on the rising edge of clock.
- State:
  - wr_ptr, rd_ptr in 0..DEPTH-1, wrapping from DEPTH-1 to 0 (explicit compare, not modulo 2^n).
  - count register 0..DEPTH.
  - full = (count==DEPTH), empty = (count==0).
- Reset values: wr_ptr=0, rd_ptr=0, count=0. Resulting outputs: io_enq_ready=1, io_deq_valid=0, io_count=0, io_almost_full=0, io_almost_empty=1. Memory contents are not reset. io_deq_bits is don't-care while io_deq_valid=0.
- Enqueue fire = io_enq_valid & io_enq_ready.
  - Writes mem[wr_ptr] at the edge and increments wr_ptr.
  - io_enq_ready = !full. There is no enqueue-on-full-with-dequeue; ready must not depend on io_deq_ready.
- Dequeue fire = io_deq_valid & io_deq_ready.
  - Increments rd_ptr.
  - io_deq_bits = mem[rd_ptr], combinational read (first-word-fall-through). An entry is visible on deq the cycle after it is enqueued.
- Count update: count_next = count + enq_fire - deq_fire. Simultaneous enq and deq leaves count unchanged and advances both pointers.
- FLOW=1 and empty:
  - io_deq_valid = io_enq_valid and io_deq_bits = io_enq_bits (zero latency).
  - If both fire in the same cycle, no memory write occurs and no pointer or count changes.
  - If enq fires without deq, the entry is written normally.
- FLOW=0: io_deq_valid = !empty, no combinational enq->deq path.
- Flush: io_flush=1 at an edge sets wr_ptr=rd_ptr=0 and count=0.
  - Any enq/deq fire in that cycle is discarded.
  - io_enq_ready and io_deq_valid are not gated by io_flush in the flush cycle itself.
  - Reset has priority over flush.
- Reset mid-operation: all contents are lost; outputs return to reset values the cycle after reset is sampled.
- Flags: io_almost_full and io_almost_empty are combinational from registered count, so they have no dependency on enq/deq inputs.
- Illegal parameters (DEPTH<2, AFULL_TH>DEPTH) are caught with an elaboration-time error.

Decomposition:
- Shared package vta_queue_pkg:
  - ptr_w(DEPTH) = $clog2(DEPTH).
  - cnt_w(DEPTH) = $clog2(DEPTH+1).
  - Parameter-check function.
- Sub-module sync_queue_mem:
  - WIDTH x DEPTH two-port array, 1 write port (clocked), 1 asynchronous read port.
  - Kept separate so it can be swapped for an SRAM macro wrapper later.

Test Plan:
- Reset then idle (WIDTH=128, DEPTH=4) -> enq_ready=1, deq_valid=0, count=0, almost_empty=1.
- Enqueue 0x1,0x2,0x3,0x4 back-to-back with deq_ready=0:
  - count 1,2,3,4.
  - enq_ready=0 after the fourth fire; almost_full=1 once count>=3.
  - A fifth offer (0x5) is not accepted.
- From full, deq_ready=1 with enq_valid=1 carrying 0x5:
  - Dequeue order is 0x1..0x4.
  - 0x5 is accepted only once count<4, and appears after 0x4.
- Wrap with DEPTH=5 (non-power-of-2): stream 0..19 with random ready/valid -> output sequence 0..19 in order, no loss or duplication, count never exceeds 5.
- FLOW=1, empty, enq_valid=1 with 0xAB, deq_ready=1 -> deq_valid=1 and deq_bits=0xAB in the same cycle; count stays 0.
- count=3 with io_flush=1 plus a simultaneous enq of 0x7 -> next cycle count=0, deq_valid=0; 0x7 is never dequeued.
